branch_target_buffer: RTL and testbench

//  Direct-mapped BTB with 2-bit saturating direction counters; the predictor end of the branch-resolution interface.

---
 rtl/branch_target_buffer.sv | 98 +++++++++
 tb/tb_branch_target_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters. Lookup is combinational with zero latency, and training lands on the next clk edge.
// There is no backpressure: resolve updates are accepted every RUN cycle and dropped while the init sweep runs.
module branch_target_buffer #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        predTaken,
    output logic [31:0] predTarget,
    output logic        btbReady,
    input  logic        exResolve,
    input  logic        exTaken,
    input  logic        exIsJalr,
    input  logic [31:0] exPc,
    input  logic [31:0] exTarget,
    input  logic        exMispredict,
    output logic [31:0] mispredCount
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [31:0]      tgt;
        logic [1:0]       ctr;
    } entry_t;

    state_t           state;
    logic [IDX_W-1:0] init_idx;
    entry_t           tbl [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] x_idx;
    logic [TAG_W-1:0] x_tag;
    logic             x_hit;
    logic [1:0]       x_ctr;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = ^{pcF[1:0], exPc[1:0]};

    assign f_idx = pcF[IDX_W+1:2];
    assign f_tag = pcF[31:IDX_W+2];
    assign x_idx = exPc[IDX_W+1:2];
    assign x_tag = exPc[31:IDX_W+2];

    // Lookup sees pre-update contents; a same-cycle write is not bypassed.
    assign f_hit      = (state == S_RUN) && tbl[f_idx].vld && (tbl[f_idx].tag == f_tag);
    assign predTaken  = f_hit && tbl[f_idx].ctr[1];
    assign predTarget = predTaken ? tbl[f_idx].tgt : 32'd0;

    assign x_hit = tbl[x_idx].vld && (tbl[x_idx].tag == x_tag);
    assign x_ctr = tbl[x_idx].ctr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_INIT;
            init_idx     <= '0;
            btbReady     <= 1'b0;
            mispredCount <= 32'd0;
        end else if (state == S_INIT) begin
            tbl[init_idx].vld <= 1'b0;
            tbl[init_idx].ctr <= 2'b01;
            init_idx          <= init_idx + IDX_W'(1);
            if (init_idx == IDX_W'(ENTRIES - 1)) begin
                state    <= S_RUN;
                btbReady <= 1'b1;
            end
        end else if (exResolve) begin
            if (exMispredict)
                mispredCount <= mispredCount + 32'd1;
            // JALR targets depend on rs1, so a hit is dropped and a miss never allocates.
            if (exIsJalr) begin
                if (x_hit)
                    tbl[x_idx].vld <= 1'b0;
            end else if (exTaken) begin
                if (x_hit) begin
                    tbl[x_idx].tgt <= exTarget;
                    if (x_ctr != 2'b11)
                        tbl[x_idx].ctr <= x_ctr + 2'd1;
                end else begin
                    tbl[x_idx].vld <= 1'b1;
                    tbl[x_idx].tag <= x_tag;
                    tbl[x_idx].tgt <= exTarget;
                    tbl[x_idx].ctr <= 2'b10;
                end
            end else if (x_hit && x_ctr != 2'b00) begin
                tbl[x_idx].ctr <= x_ctr - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: init sweep, allocation, counter training, JALR, no-bypass, mispredict count.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        btbReady;
    logic        exResolve;
    logic        exTaken;
    logic        exIsJalr;
    logic [31:0] exPc;
    logic [31:0] exTarget;
    logic        exMispredict;
    logic [31:0] mispredCount;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer #(.ENTRIES(64)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .predTaken(predTaken), .predTarget(predTarget),
        .btbReady(btbReady), .exResolve(exResolve), .exTaken(exTaken), .exIsJalr(exIsJalr),
        .exPc(exPc), .exTarget(exTarget), .exMispredict(exMispredict), .mispredCount(mispredCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the resolve is consumed by the following posedge.
    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic jr, input logic mp);
        exResolve = 1'b1; exPc = pc; exTarget = tgt;
        exTaken = tk; exIsJalr = jr; exMispredict = mp;
        @(negedge clk);
        exResolve = 1'b0; exTaken = 1'b0; exIsJalr = 1'b0; exMispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        pcF = pc;
        #1;
    endtask

    // Counts not-ready cycles starting at the current negedge; bounded.
    task automatic wait_ready(output int zeros, output int pt_seen);
        zeros = 0;
        pt_seen = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (btbReady) break;
            zeros++;
            if (predTaken || predTarget != 32'd0) pt_seen++;
            @(negedge clk);
        end
    endtask

    int zeros, pt_seen;

    initial begin
        rst = 1'b1; pcF = 32'h100; exResolve = 1'b0; exTaken = 1'b0; exIsJalr = 1'b0;
        exPc = 32'd0; exTarget = 32'd0; exMispredict = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, btbReady}, 32'd0);
        check("rst_count", mispredCount, 32'd0);
        check("rst_pt", {31'd0, predTaken}, 32'd0);
        check("rst_ptgt", predTarget, 32'd0);
        rst = 1'b0;

        wait_ready(zeros, pt_seen);
        check("sweep_len", zeros, 32'd64);
        check("sweep_pt", pt_seen, 32'd0);
        check("ready_high", {31'd0, btbReady}, 32'd1);

        // Allocate and alias check
        resolve(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
        look(32'h100);
        check("alloc_pt", {31'd0, predTaken}, 32'd1);
        check("alloc_tgt", predTarget, 32'h80);
        look(32'h200);
        check("alias_pt", {31'd0, predTaken}, 32'd0);
        check("alias_tgt", predTarget, 32'd0);

        // Counter training from 2'b10
        pcF = 32'h100;
        resolve(32'h100, 32'h80, 1'b0, 1'b0, 1'b0); look(32'h100);
        check("nt1_pt", {31'd0, predTaken}, 32'd0);
        resolve(32'h100, 32'h80, 1'b0, 1'b0, 1'b0);
        resolve(32'h100, 32'h80, 1'b0, 1'b0, 1'b0);
        resolve(32'h100, 32'h80, 1'b1, 1'b0, 1'b0); look(32'h100);
        check("dec_sat_pt", {31'd0, predTaken}, 32'd0);
        resolve(32'h100, 32'h84, 1'b1, 1'b0, 1'b0); look(32'h100);
        check("t2_pt", {31'd0, predTaken}, 32'd1);
        check("t2_tgt", predTarget, 32'h84);
        resolve(32'h100, 32'h84, 1'b1, 1'b0, 1'b0);
        resolve(32'h100, 32'h88, 1'b1, 1'b0, 1'b0);
        resolve(32'h100, 32'h88, 1'b0, 1'b0, 1'b0); look(32'h100);
        check("inc_sat_pt", {31'd0, predTaken}, 32'd1);
        check("inc_sat_tgt", predTarget, 32'h88);
        resolve(32'h100, 32'h88, 1'b0, 1'b0, 1'b0); look(32'h100);
        check("weak_nt_pt", {31'd0, predTaken}, 32'd0);

        // JALR invalidates a hit and never allocates
        resolve(32'h100, 32'h90, 1'b1, 1'b0, 1'b0); look(32'h100);
        check("retrain_pt", {31'd0, predTaken}, 32'd1);
        resolve(32'h100, 32'h90, 1'b1, 1'b1, 1'b0); look(32'h100);
        check("jalr_inv_pt", {31'd0, predTaken}, 32'd0);
        resolve(32'h4C, 32'h700, 1'b1, 1'b1, 1'b0); look(32'h4C);
        check("jalr_noalloc", {31'd0, predTaken}, 32'd0);

        // Not-taken miss leaves the resident entry alone
        resolve(32'h104, 32'h10, 1'b1, 1'b0, 1'b0);
        resolve(32'h204, 32'h20, 1'b0, 1'b0, 1'b0); look(32'h104);
        check("ntmiss_pt", {31'd0, predTaken}, 32'd1);
        check("ntmiss_tgt", predTarget, 32'h10);

        // Same-cycle allocate and lookup: no bypass
        pcF = 32'h40;
        exResolve = 1'b1; exPc = 32'h40; exTarget = 32'h1234; exTaken = 1'b1;
        #1;
        check("bypass_pt", {31'd0, predTaken}, 32'd0);
        @(negedge clk);
        exResolve = 1'b0; exTaken = 1'b0;
        #1;
        check("after_pt", {31'd0, predTaken}, 32'd1);
        check("after_tgt", predTarget, 32'h1234);

        // Mispredict counting
        for (int i = 0; i < 5; i++) resolve(32'h500, 32'h0, 1'b0, 1'b0, 1'b1);
        exMispredict = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exMispredict = 1'b0;
        check("misp_count", mispredCount, 32'd5);

        // Reset mid-sweep at index 30
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) @(negedge clk);
        check("mid_ready", {31'd0, btbReady}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_count", mispredCount, 32'd0);
        // Resolves during the sweep must be ignored
        pcF = 32'h40;
        exResolve = 1'b1; exPc = 32'h40; exTarget = 32'h55; exTaken = 1'b1; exMispredict = 1'b1;
        wait_ready(zeros, pt_seen);
        exResolve = 1'b0; exTaken = 1'b0; exMispredict = 1'b0;
        check("sweep2_len", zeros, 32'd64);
        check("sweep2_pt", pt_seen, 32'd0);
        look(32'h40);
        check("init_cleared", {31'd0, predTaken}, 32'd0);
        check("init_count", mispredCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
